spi_reg_bridge: RTL

//  Parametrised SPI mode-0 slave that bridges an external SPI master to the on-chip register file.
//  All SPI pins are oversampled in the main clock domain; the block drives a single-cycle

---
 rtl/spi_bridge_pkg.sv | 15 +
 rtl/spi_pin_sync.sv | 41 ++++
 rtl/spi_reg_bridge.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-file bridge.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_RD_FETCH = 3'd2,
        ST_DATA     = 3'd3,
        ST_WAIT_CS  = 3'd4
    } state_t;

    localparam int CMD_W      = 8;
    localparam int CMD_RW_BIT = 7;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with a delayed level
// and registered single-clock rise/fall pulses aligned to that level.
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic level_r;
    logic rise_r;
    logic fall_r;

    // Synchroniser chain and edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r  <= RESET_VAL;
            sync_r  <= RESET_VAL;
            level_r <= RESET_VAL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            meta_r  <= pin;
            sync_r  <= meta_r;
            level_r <= sync_r;
            rise_r  <= sync_r & ~level_r;
            fall_r  <= ~sync_r & level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave bridging an external master onto single-cycle register strobes.
// Optional burst auto-increment is enabled by defining SPI_BURST_EN.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] address,
    output logic              write_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              read_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [1:0]       FETCH_LAST = 2'(RD_LATENCY);
`ifdef SPI_BURST_EN
    localparam logic BURST = 1'b1;
`else
    localparam logic BURST = 1'b0;
`endif

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_bit, mosi_rise, mosi_fall;
    logic unused_sync_s;

    state_t            state_r, next_state_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [1:0]        fetch_cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              is_read_r;
    logic              wait_err_r;

    logic              miso_r, write_en_r, read_en_r, busy_r, frame_err_r;
    logic [ADDR_W-1:0] address_r;
    logic [DATA_W-1:0] wr_data_r;

    logic              miso_s, write_en_s, read_en_s, busy_s, frame_err_s;
    logic [DATA_W-1:0] shift_in_s;
    logic              cmd_done_s, word_done_s, fetch_done_s, cmd_read_s, partial_s;

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clock(clock), .reset_n(reset_n), .pin(spi_clk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));

    // cs_n resets to "low" so a frame already running at reset release never shows a fall
    spi_pin_sync #(.RESET_VAL(1'b0)) u_cs_sync (
        .clock(clock), .reset_n(reset_n), .pin(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall));

    spi_pin_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clock(clock), .reset_n(reset_n), .pin(mosi),
        .level(mosi_bit), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_sync_s = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

    assign shift_in_s   = {shift_r[DATA_W-2:0], mosi_bit};
    assign cmd_read_s   = shift_in_s[CMD_RW_BIT];
    assign cmd_done_s   = (state_r == ST_CMD) && sclk_rise && (bit_cnt_r == CMD_LAST);
    assign word_done_s  = (state_r == ST_DATA) && sclk_rise && (bit_cnt_r == DATA_LAST);
    assign fetch_done_s = (state_r == ST_RD_FETCH) && (fetch_cnt_r == FETCH_LAST);
    assign partial_s    = ((state_r == ST_CMD) || (state_r == ST_DATA)) &&
                          (bit_cnt_r != {CNT_W{1'b0}}) && !cmd_done_s && !word_done_s;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; cs_n rise overrides everything
    always_comb begin
        next_state_s = state_r;
        if (cs_rise) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall) next_state_s = ST_CMD;
                    else         next_state_s = ST_IDLE;
                end
                ST_CMD: begin
                    if (cmd_done_s) next_state_s = cmd_read_s ? ST_RD_FETCH : ST_DATA;
                    else            next_state_s = ST_CMD;
                end
                ST_RD_FETCH: begin
                    if (fetch_done_s) next_state_s = ST_DATA;
                    else              next_state_s = ST_RD_FETCH;
                end
                ST_DATA: begin
                    if (word_done_s && BURST)  next_state_s = is_read_r ? ST_RD_FETCH : ST_DATA;
                    else if (word_done_s)      next_state_s = ST_WAIT_CS;
                    else                       next_state_s = ST_DATA;
                end
                ST_WAIT_CS: next_state_s = ST_WAIT_CS;
                default:    next_state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode, registered below
    always_comb begin
        busy_s     = (next_state_s != ST_IDLE);
        write_en_s = word_done_s && !is_read_r;
        read_en_s  = !cs_rise && ((cmd_done_s && cmd_read_s) ||
                                  (BURST && word_done_s && is_read_r));
        if (cs_rise && partial_s) begin
            frame_err_s = 1'b1;
        end else if ((state_r == ST_WAIT_CS) && sclk_rise && !wait_err_r) begin
            frame_err_s = 1'b1;
        end else begin
            frame_err_s = 1'b0;
        end
        // MSB is loaded at fetch; later bits shift out on falls that follow a sampled rise
        if ((next_state_s == ST_DATA) && is_read_r &&
            ((state_r == ST_RD_FETCH) || (state_r == ST_DATA))) begin
            if (fetch_done_s) begin
                miso_s = rd_data[DATA_W-1];
            end else if ((state_r == ST_DATA) && sclk_fall && (bit_cnt_r != {CNT_W{1'b0}})) begin
                miso_s = shift_r[DATA_W-2];
            end else begin
                miso_s = miso_r;
            end
        end else begin
            miso_s = 1'b0;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_r   <= {CNT_W{1'b0}};
            fetch_cnt_r <= 2'd0;
            shift_r     <= {DATA_W{1'b0}};
            is_read_r   <= 1'b0;
            wait_err_r  <= 1'b0;
            miso_r      <= 1'b0;
            address_r   <= {ADDR_W{1'b0}};
            write_en_r  <= 1'b0;
            wr_data_r   <= {DATA_W{1'b0}};
            read_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            miso_r      <= miso_s;
            write_en_r  <= write_en_s;
            read_en_r   <= read_en_s;
            busy_r      <= busy_s;
            frame_err_r <= frame_err_s;
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r   <= {CNT_W{1'b0}};
                    fetch_cnt_r <= 2'd0;
                    wait_err_r  <= 1'b0;
                end
                ST_CMD: begin
                    if (cmd_done_s) begin
                        address_r   <= shift_in_s[ADDR_W-1:0];
                        is_read_r   <= cmd_read_s;
                        bit_cnt_r   <= {CNT_W{1'b0}};
                        fetch_cnt_r <= 2'd0;
                    end else if (sclk_rise) begin
                        shift_r   <= shift_in_s;
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_RD_FETCH: begin
                    if (fetch_done_s) shift_r <= rd_data;
                    else              fetch_cnt_r <= fetch_cnt_r + 2'd1;
                end
                ST_DATA: begin
                    if (word_done_s) begin
                        bit_cnt_r   <= {CNT_W{1'b0}};
                        fetch_cnt_r <= 2'd0;
                        if (!is_read_r) begin
                            shift_r   <= shift_in_s;
                            wr_data_r <= shift_in_s;
                        end else if (BURST) begin
                            address_r <= address_r + ADDR_W'(1);
                        end
                    end else if (sclk_rise) begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        if (!is_read_r) shift_r <= shift_in_s;
                    end else if (sclk_fall && is_read_r && (bit_cnt_r != {CNT_W{1'b0}})) begin
                        shift_r <= shift_r << 1;
                    end
                    // Write address advances only after its strobe has been seen
                    if (BURST && write_en_r && !is_read_r) begin
                        address_r <= address_r + ADDR_W'(1);
                    end
                end
                ST_WAIT_CS: begin
                    if (sclk_rise) wait_err_r <= 1'b1;
                end
                default: begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign miso      = miso_r;
    assign address   = address_r;
    assign write_en  = write_en_r;
    assign wr_data   = wr_data_r;
    assign read_en   = read_en_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;

endmodule
